// File: rtl/conv3x3_alu.sv
// conv3x3_alu: 3x3 signed-weight convolution with ReLU, shift, saturate and 4-byte packing.
// Latency: window accepted in cycle n -> byte packed at end of n+2 -> out_valid in n+3.
// Backpressure: none; every accepted window yields one byte, bubbles pass as empty slots.
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   w_load, w_data    weight write strobe and signed 8-bit weight (k0..k8 in order)
//   w_ready           all nine weights loaded
//   pix_valid         X_reg1..X_reg3 hold a valid 3x3 window this cycle
//   X_reg1..X_reg3    kernel rows 0..2, column c in byte c, unsigned pixels
//   out_valid         one-cycle pulse, out_data carries a new packed word
//   out_data          four results, earliest in [7:0]; held between pulses
//   row_end           pulses with the 7th word (columns 24..27) of a row
//   busy              a pipeline stage holds a valid entry
module conv3x3_alu #(
  parameter int SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_load,
  input  logic [7:0]  w_data,
  output logic        w_ready,
  input  logic        pix_valid,
  input  logic [23:0] X_reg1,
  input  logic [23:0] X_reg2,
  input  logic [23:0] X_reg3,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        row_end,
  output logic        busy
);

  localparam int NTAP      = 9;
  localparam int ROW_BYTES = 28;

  // ---------------------------------------------------------------------------
  // Weight store
  // ---------------------------------------------------------------------------
  logic signed [7:0] weight [NTAP];
  logic        [3:0] w_idx;     // next weight slot to write while w_ready=0
  logic              w_write;

  // Weights must not change under in-flight windows, so loads wait for idle.
  assign w_write = w_load & ~busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NTAP; k++) weight[k] <= '0;
      w_idx   <= '0;
      w_ready <= 1'b0;
    end else if (w_write) begin
      if (w_ready) begin
        // A load after a full set starts a new set at k0; k1..k8 keep
        // their old values until rewritten.
        weight[0] <= w_data;
        w_idx     <= 4'd1;
        w_ready   <= 1'b0;
      end else begin
        for (int k = 0; k < NTAP; k++) begin
          if (w_idx == 4'(k)) weight[k] <= w_data;
        end
        if (w_idx == 4'(NTAP - 1)) begin
          w_idx   <= '0;
          w_ready <= 1'b1;
        end else begin
          w_idx <= w_idx + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window unpack: tap 3*r+c takes row r, column c
  // ---------------------------------------------------------------------------
  logic [7:0] pix [NTAP];

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      pix[c]     = X_reg1[8*c +: 8];
      pix[3 + c] = X_reg2[8*c +: 8];
      pix[6 + c] = X_reg3[8*c +: 8];
    end
  end

  logic accept;
  assign accept = pix_valid & w_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: nine unsigned-pixel x signed-weight products
  // ---------------------------------------------------------------------------
  logic               v1;
  logic signed [16:0] prod [NTAP];

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1 <= 1'b0;
      for (int k = 0; k < NTAP; k++) prod[k] <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        // Zero-extended pixel keeps it non-negative in the signed multiply;
        // 9b x 8b signed fits 17 bits (range -32640..32385).
        for (int k = 0; k < NTAP; k++) begin
          prod[k] <= $signed({1'b0, pix[k]}) * weight[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: sum of products; 9 x 17-bit signed cannot exceed 21 bits
  // ---------------------------------------------------------------------------
  logic               v2;
  logic signed [20:0] sum_c;
  logic signed [20:0] sum_q;

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NTAP; k++) sum_c = sum_c + 21'(prod[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v2    <= 1'b0;
      sum_q <= '0;
    end else begin
      v2 <= v1;
      if (v1) sum_q <= sum_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: ReLU, shift, saturate to one byte; written into the packer
  // ---------------------------------------------------------------------------
  logic [19:0] relu;
  logic [19:0] shifted;
  logic [7:0]  res_byte;

  always_comb begin
    relu     = sum_q[20] ? 20'd0 : sum_q[19:0];
    shifted  = relu >> SHIFT;
    res_byte = (shifted > 20'd255) ? 8'hFF : shifted[7:0];
  end

  // v3 marks that a byte landed in the packer on the previous edge, so busy
  // stays up until its word (if completed) has been presented.
  logic        v3;
  logic [23:0] pack_buf;    // bytes 0..2 of the word being assembled
  logic [1:0]  byte_idx;
  logic [4:0]  col;

  always_ff @(posedge clk) begin
    if (!rst) begin
      v3        <= 1'b0;
      pack_buf  <= '0;
      byte_idx  <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      row_end   <= 1'b0;
    end else begin
      v3        <= v2;
      out_valid <= 1'b0;
      row_end   <= 1'b0;
      if (v2) begin
        case (byte_idx)
          2'd0: pack_buf[7:0]   <= res_byte;
          2'd1: pack_buf[15:8]  <= res_byte;
          2'd2: pack_buf[23:16] <= res_byte;
          default: begin
            out_data  <= {res_byte, pack_buf};
            out_valid <= 1'b1;
            row_end   <= (col == 5'(ROW_BYTES - 1));
          end
        endcase
        byte_idx <= byte_idx + 2'd1;
        col      <= (col == 5'(ROW_BYTES - 1)) ? 5'd0 : col + 5'd1;
      end
    end
  end

  assign busy = v1 | v2 | v3;

endmodule

// File: tb/tb_conv3x3_alu.sv
// tb_conv3x3_alu: randomized and directed stimulus against a cycle-indexed reference model.
// Latency: model schedules each packed word 3 cycles after the window completing it.
// Backpressure: none in the DUT; the bench drives one input set per cycle.
module tb_conv3x3_alu;

  localparam int SHIFT = 4;
  localparam int N     = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_load = 1'b0;
  logic [7:0]  w_data = '0;
  logic        w_ready;
  logic        pix_valid = 1'b0;
  logic [23:0] X_reg1 = '0, X_reg2 = '0, X_reg3 = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        row_end;
  logic        busy;

  conv3x3_alu #(.SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_data(w_data), .w_ready(w_ready),
    .pix_valid(pix_valid), .X_reg1(X_reg1), .X_reg2(X_reg2), .X_reg3(X_reg3),
    .out_valid(out_valid), .out_data(out_data), .row_end(row_end), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per-cycle event tables filled as inputs are applied.
  bit          acc    [N];   // window accepted in this cycle
  bit          rst_at [N];   // reset applied in this cycle
  bit          ov_at  [N];   // out_valid expected in this cycle
  bit          re_at  [N];
  logic [31:0] word_at[N];
  bit          wr_at  [N];   // expected w_ready in this cycle

  int          mw[9];
  int          widx = 0;
  bit          mwr = 0;
  int          mn = 0;
  int          mcol = 0;
  logic [31:0] mword = '0;

  int n_chk = 0, n_err = 0;
  bit chk_en = 0;
  int ov_cnt = 0, re_cnt = 0, first_ov = -1;
  logic [31:0] hold = '0;

  function automatic int conv_byte(input int px[9], input int wt[9]);
    int s = 0;
    for (int k = 0; k < 9; k++) s += px[k] * wt[k];
    if (s < 0) s = 0;
    s = s >>> SHIFT;
    if (s > 255) s = 255;
    return s;
  endfunction

  // Busy when any window accepted in the last three cycles survived resets.
  function automatic bit busy_exp(input int c);
    for (int k = 1; k <= 3; k++) begin
      int j = c - k;
      if (j >= 0 && acc[j]) begin
        bit killed = 0;
        for (int i = j; i < c; i++) if (rst_at[i]) killed = 1;
        if (!killed) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%08h expected=0x%08h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit rv, input bit wl, input logic [7:0] wd, input bit pv,
                       input logic [23:0] x1, input logic [23:0] x2, input logic [23:0] x3);
    int c;
    int px[9];
    logic [23:0] rows[3];
    int b;
    bit bz;
    c = cyc;
    if (c > N - 8) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", c, N - 8);
      $fatal(1, "cycle budget exhausted");
    end
    rst = rv; w_load = wl; w_data = wd; pix_valid = pv;
    X_reg1 = x1; X_reg2 = x2; X_reg3 = x3;
    if (!rv) begin
      rst_at[c] = 1;
      for (int k = 1; k <= 3; k++) ov_at[c + k] = 0;
      for (int k = 0; k < 9; k++) mw[k] = 0;
      widx = 0; mwr = 0; mn = 0; mcol = 0; mword = '0;
      acc[c] = 0;
    end else begin
      bz = busy_exp(c);
      acc[c] = pv && mwr;
      if (acc[c]) begin
        rows[0] = x1; rows[1] = x2; rows[2] = x3;
        for (int r = 0; r < 3; r++)
          for (int col = 0; col < 3; col++)
            px[3*r + col] = int'(rows[r][8*col +: 8]);
        b = conv_byte(px, mw);
        mword[8*mn +: 8] = 8'(b);
        mn++;
        mcol++;
        if (mn == 4) begin
          ov_at[c + 3]   = 1;
          word_at[c + 3] = mword;
          re_at[c + 3]   = (mcol == 28);
          if (mcol == 28) mcol = 0;
          mn = 0;
        end
      end
      if (wl && !bz) begin
        if (mwr) begin
          mw[0] = int'($signed(wd)); widx = 1; mwr = 0;
        end else begin
          mw[widx] = int'($signed(wd));
          if (widx == 8) begin widx = 0; mwr = 1; end
          else widx++;
        end
      end
    end
    wr_at[c + 1] = mwr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 8'h00, 0, 24'h0, 24'h0, 24'h0);
  endtask

  task automatic load_w(input int w[9]);
    for (int k = 0; k < 9; k++) drive(1, 1, 8'(w[k]), 0, 24'h0, 24'h0, 24'h0);
  endtask

  task automatic stream(input int n, input bit alt, input logic [23:0] x1,
                        input logic [23:0] x2, input logic [23:0] x3);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 8'h00, 1, x1, x2, x3);
      if (alt) drive(1, 0, 8'h00, 0, 24'h0, 24'h0, 24'h0);
    end
  endtask

  // Single compare process: every output, every cycle after the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      int c;
      c = cyc;
      if (c > 0 && rst_at[c - 1]) hold = '0;
      if (ov_at[c]) hold = word_at[c];
      chk("out_valid", 32'(out_valid), 32'(ov_at[c]));
      chk("out_data", out_data, hold);
      chk("row_end", 32'(row_end), 32'(ov_at[c] && re_at[c]));
      chk("busy", 32'(busy), 32'(busy_exp(c)));
      chk("w_ready", 32'(w_ready), 32'(wr_at[c]));
      if (out_valid === 1'b1) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = c;
      end
      if (row_end === 1'b1) re_cnt++;
    end
  end

  initial begin
    int w[9];
    int px[9];
    int s;
    logic [7:0] rw;

    for (int k = 0; k < 9; k++) mw[k] = 0;
    drive(0, 0, 8'h00, 0, 24'h0, 24'h0, 24'h0);
    drive(0, 0, 8'h00, 0, 24'h0, 24'h0, 24'h0);
    chk_en = 1;

    // Hand-computed pins for the model arithmetic.
    for (int k = 0; k < 9; k++) begin w[k] = 1;   px[k] = 16;  end
    chk("model_basic", 32'(conv_byte(px, w)), 32'd9);
    for (int k = 0; k < 9; k++) w[k] = -1;
    chk("model_relu", 32'(conv_byte(px, w)), 32'd0);
    for (int k = 0; k < 9; k++) begin w[k] = 127; px[k] = 255; end
    chk("model_sat", 32'(conv_byte(px, w)), 32'd255);
    for (int k = 0; k < 9; k++) begin w[k] = (k == 4) ? 1 : 0; px[k] = (k == 4) ? 42 : 0; end
    chk("model_pos", 32'(conv_byte(px, w)), 32'd2);

    // Pixels ignored before weights are ready.
    stream(4, 0, 24'h101010, 24'h101010, 24'h101010);
    idle(4);

    // Basic: weights 1, pixels 16, one full row.
    for (int k = 0; k < 9; k++) w[k] = 1;
    load_w(w);
    ov_cnt = 0; re_cnt = 0; first_ov = -1;
    s = cyc;
    stream(28, 0, 24'h101010, 24'h101010, 24'h101010);
    idle(8);
    chk("basic_first_ov", 32'(first_ov), 32'(s + 6));
    chk("basic_words", 32'(ov_cnt), 32'd7);
    chk("basic_row_end", 32'(re_cnt), 32'd1);
    chk("basic_data", out_data, 32'h09090909);

    // Bubbles: alternating valid, same row.
    ov_cnt = 0; re_cnt = 0;
    stream(28, 1, 24'h101010, 24'h101010, 24'h101010);
    idle(8);
    chk("bubble_words", 32'(ov_cnt), 32'd7);
    chk("bubble_row_end", 32'(re_cnt), 32'd1);
    chk("bubble_data", out_data, 32'h09090909);

    // ReLU: weights -1 (reload restarts from k0 while w_ready=1).
    for (int k = 0; k < 9; k++) w[k] = -1;
    load_w(w);
    for (int i = 0; i < 28; i++)
      drive(1, 0, 8'h00, 1, 24'($urandom()), 24'($urandom()), 24'($urandom()));
    idle(8);
    chk("relu_data", out_data, 32'h00000000);

    // Saturation: weights 127, pixels 255.
    for (int k = 0; k < 9; k++) w[k] = 127;
    load_w(w);
    stream(28, 0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    idle(8);
    chk("sat_data", out_data, 32'hFFFFFFFF);

    // Positional: only centre tap.
    for (int k = 0; k < 9; k++) w[k] = (k == 4) ? 1 : 0;
    load_w(w);
    stream(28, 0, 24'h000000, 24'h002A00, 24'h000000);
    idle(8);
    chk("pos_data", out_data, 32'h02020202);

    // Control: loads during busy are ignored.
    for (int k = 0; k < 9; k++) w[k] = 1;
    load_w(w);
    stream(6, 0, 24'h101010, 24'h101010, 24'h101010);
    drive(1, 1, 8'h7F, 1, 24'h101010, 24'h101010, 24'h101010);
    drive(1, 1, 8'h7F, 1, 24'h101010, 24'h101010, 24'h101010);
    stream(20, 0, 24'h101010, 24'h101010, 24'h101010);
    idle(8);
    chk("busy_load_data", out_data, 32'h09090909);
    // Load with w_ready=1 drops w_ready on the next cycle.
    drive(1, 1, 8'h01, 0, 24'h0, 24'h0, 24'h0);
    chk("reload_w_ready", 32'(w_ready), 32'd0);
    for (int k = 1; k < 9; k++) drive(1, 1, 8'h01, 0, 24'h0, 24'h0, 24'h0);
    idle(2);

    // Reset mid-row: nothing follows it.
    stream(10, 0, 24'h101010, 24'h101010, 24'h101010);
    drive(0, 0, 8'h00, 0, 24'h0, 24'h0, 24'h0);
    ov_cnt = 0;
    stream(4, 0, 24'h101010, 24'h101010, 24'h101010);
    idle(10);
    chk("post_reset_ov", 32'(ov_cnt), 32'd0);
    chk("post_reset_data", out_data, 32'h00000000);

    // Randomized: random weights, pixels, bubbles and occasional reloads.
    for (int k = 0; k < 9; k++) w[k] = int'($signed(8'($urandom())));
    load_w(w);
    for (int i = 0; i < 500; i++) begin
      rw = 8'($urandom());
      drive(1, ($urandom_range(49) == 0), rw, ($urandom_range(3) != 0),
            24'($urandom()), 24'($urandom()), 24'($urandom()));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/conv3x3_alu.md
CONV3X3_ALU -- requirements
Module: conv3x3_alu

Interface
REQ-001 SHALL have parameter SHIFT, default 4: right-shift applied to the clamped 3x3 sum before saturation.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  in  1: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port w_load  in  1: weight write strobe, one weight per cycle.
REQ-005 SHALL have port w_data  in  8: signed two's-complement weight.
REQ-006 SHALL have port w_ready  out  1: high when all 9 weights are loaded.
REQ-007 SHALL have port pix_valid  in  1: the X_reg1..X_reg3 window is valid this cycle (driven by the X_buffer shift enable).
REQ-008 SHALL have ports X_reg1, X_reg2, X_reg3  in  24 each: kernel rows 0..2; byte [7:0] = column 0, [15:8] = column 1, [23:16] = column 2; pixels unsigned 8-bit.
REQ-009 SHALL have port out_valid  out  1: one-cycle pulse when out_data holds a new word.
REQ-010 SHALL have port out_data  out  32: four packed results, earliest in [7:0].
REQ-011 SHALL have port row_end  out  1: pulses together with out_valid for the 7th word of a row.
REQ-012 SHALL have port busy  out  1: high while any pipeline stage holds a valid entry.

Function
REQ-013 Weight k SHALL be at index 3*r+c, loaded in order k0..k8 on successive w_load cycles (gaps allowed); w_ready SHALL rise in the cycle after k8 is written.
REQ-014 w_load with w_ready=1 SHALL restart loading: write k0, clear w_ready; the remaining weights keep their old values until overwritten.
REQ-015 w_load while busy=1 SHALL be ignored; pix_valid while w_ready=0 SHALL be ignored.
REQ-016 Stage 1 SHALL register nine products pixel(unsigned) * weight(signed), each 17-bit signed.
REQ-017 Stage 2 SHALL register their sum as 21-bit signed; overflow is impossible.
REQ-018 Stage 3 SHALL clamp negative sums to 0 (ReLU), shift right by SHIFT, saturate to 255, and produce one byte.
REQ-019 Latency: a pixel window accepted in cycle n SHALL yield its byte in the packer at the end of cycle n+2; if that byte completes a word, out_valid SHALL be high in cycle n+3.
REQ-020 Bubbles (pix_valid=0) SHALL propagate as invalid slots without disturbing the packer; there is no backpressure.
REQ-021 The packer SHALL place the byte-index-0..3 results in [7:0], [15:8], [23:16], [31:24] and fire out_valid on the 4th byte.
REQ-022 out_data SHALL hold its value between out_valid pulses.
REQ-023 The column counter SHALL count packed bytes 0..27 and wrap to 0 after 27; row_end SHALL pulse with the word that contains column 27.
REQ-024 The byte-in-word counter SHALL wrap 3->0; a row is exactly 7 words.
REQ-025 busy SHALL equal the OR of the stage-1 and stage-2 valid bits and the stage-3 valid bit.

Reset
REQ-026 On rst=0 at a clock edge: all weights 0, w_ready 0, pipeline valid bits 0, packer and counters 0, out_data 0x00000000, out_valid 0, row_end 0, busy 0.
REQ-027 Reset mid-row SHALL discard in-flight results; no out_valid SHALL follow the reset.

Verification
REQ-028 Basic: load weights all 1, pixels all 16, 28 consecutive pix_valid -> sum 144, 144>>4=9; 7 words of 0x09090909; first out_valid 3 cycles after the 4th pix_valid; row_end on the 7th word only.
REQ-029 ReLU/saturation: weights all -1 -> 0x00000000; weights all 127, pixels 255 -> 291465>>4=18216, saturated -> 0xFFFFFFFF.
REQ-030 Positional: only k4=1 (others 0), X_reg2=0x00_2A_00 -> each byte 42>>4=2; a k-order swap shows up as 0.
REQ-031 Bubbles: pix_valid alternating 1/0 for 56 cycles -> same 7 words as REQ-028, evenly spaced, row_end on the 7th.
REQ-032 Control: w_load during busy is ignored (results unchanged); w_load after w_ready drops w_ready next cycle; rst=0 after 10 pixels -> no further out_valid, all outputs 0.
